spi_frame_fifo: RTL
===================

SPI_FRAME_FIFO -- requirements
Module: spi_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe per completed SPI frame from the upstream SPI slave.
REQ-005 SHALL have port rx_data  input  16  received frame, valid with rx_valid.
REQ-006 SHALL have port tx_load  input  1  one-cycle strobe: SPI slave latches the next outgoing word at chip-select fall.
REQ-007 SHALL have port tx_data  output  16  word offered to the SPI slave; registered.
REQ-008 SHALL have ports address_in (input, 32), sel_in (input, 1), read_in (input, 1), write_mask_in (input, 4), write_value_in (input, 32): CPU memory bus request.
REQ-009 SHALL have ports read_value_out (output, 32) and ready_out (output, 1): CPU bus response.
REQ-010 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-011 SHALL decode address_in[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
REQ-012 SHALL run a bus FSM IDLE->ACK->WAIT->IDLE: IDLE->ACK when sel_in=1; ACK lasts exactly one cycle; WAIT->IDLE when sel_in=0.
REQ-013 SHALL drive ready_out=1 only in ACK; read_value_out registered on IDLE->ACK, held through ACK, 0 otherwise.
REQ-014 SHALL perform every side effect (pop, push, clear) exactly once, on the IDLE->ACK transition.
REQ-015 DATA read SHALL return {15'b0, 1'b1, rx_head[15:0]} and pop RX when RX non-empty; when empty SHALL return 0, leave pointers unchanged, set sticky rx_underflow.
REQ-016 DATA write with write_mask_in[1:0]=2'b11 SHALL push write_value_in[15:0] to TX; when TX full SHALL drop the word and set sticky tx_overflow; other masks SHALL be ignored.
REQ-017 STATUS read SHALL return {rx_count[5:0] at bits 5:0, tx_count[5:0] at 13:8, rx_overflow bit16, rx_underflow bit17, tx_overflow bit18, tx_underrun bit19}, rest 0.
REQ-018 CTRL write (mask[0]=1) SHALL act on write_value_in: bit0 flush RX, bit1 flush TX, bit2 clear all sticky flags, bit8 irq_en stored; CTRL read returns {23'b0, irq_en, 8'b0}.
REQ-019 THRESH write (mask[0]=1) SHALL store write_value_in[5:0]; read returns it zero-extended; reset value 1.
REQ-020 rx_valid SHALL push rx_data to RX; when RX full and no pop that same cycle SHALL drop rx_data and set rx_overflow.
REQ-021 Simultaneous RX push and pop SHALL both occur, count unchanged, including when full (no overflow) and when empty (underflow flag set, the pushed word retained).
REQ-022 tx_load SHALL pop TX into tx_data register next cycle; when TX empty SHALL load 16'hFFFF and set sticky tx_underrun.
REQ-023 Simultaneous TX push and tx_load SHALL both occur; on empty TX the pushed word SHALL NOT bypass (tx_data=16'hFFFF, underrun set).
REQ-024 Flush SHALL take priority over a same-cycle push/pop on that FIFO; the FIFO SHALL be empty afterwards.
REQ-025 Pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; counts 0..DEPTH, full at DEPTH.
REQ-026 irq SHALL be registered: irq_en && (rx_count >= thresh) && thresh != 0.

Reset
REQ-027 While reset=0: FSM IDLE, all pointers/counts 0, sticky flags 0, irq_en 0, thresh 1, tx_data 16'hFFFF, read_value_out 0, ready_out 0, irq 0.
REQ-028 Reset mid-transaction SHALL abort it without side effect; after release FSM starts IDLE and reacts to a still-held sel_in as a new access.

Structure
REQ-029 Register offsets, STATUS/CTRL bit positions and FSM state enum SHALL live in shared package spi_frame_pkg.
REQ-030 Both FIFOs SHALL be instances of one sub-module sync_fifo16 (DEPTH, push, pop, flush, data, count, full, empty).

Verification
REQ-031 Push 3 rx_valid words 0x1111,0x2222,0x3333; three DATA reads -> 0x00011111, 0x00012222, 0x00013333; fourth -> 0, rx_underflow=1.
REQ-032 9 rx_valid with DEPTH=8 -> rx_count=8, rx_overflow=1, ninth word absent; rx_valid coincident with DATA read at full -> count stays 8, no overflow.
REQ-033 Write 0xABCD (mask 4'b0011) then tx_load -> tx_data=0xABCD; second tx_load -> 0xFFFF, tx_underrun=1; mask 4'b0001 write -> tx_count unchanged.
REQ-034 sel_in held 5 cycles on DATA read -> exactly one ready_out pulse, one pop.
REQ-035 irq_en=1, thresh=2: one push -> irq=0; second -> irq=1 one cycle later; CTRL flush RX -> irq=0.
REQ-036 Assert reset during ACK with RX holding 2 words -> ready_out=0, rx_count=0, tx_data=0xFFFF immediately.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared register map, status/control bit positions and bus FSM states
// for the SPI frame FIFO and its testbench.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_sel_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_t;

    localparam int STATUS_RX_COUNT_LSB = 0;
    localparam int STATUS_TX_COUNT_LSB = 8;
    localparam int STATUS_RX_OVERFLOW  = 16;
    localparam int STATUS_RX_UNDERFLOW = 17;
    localparam int STATUS_TX_OVERFLOW  = 18;
    localparam int STATUS_TX_UNDERRUN  = 19;

    localparam int CTRL_FLUSH_RX    = 0;
    localparam int CTRL_FLUSH_TX    = 1;
    localparam int CTRL_CLEAR_FLAGS = 2;
    localparam int CTRL_IRQ_EN      = 8;

    // Word handed to the SPI slave whenever the TX FIFO has nothing to give.
    localparam logic [15:0] TX_IDLE_WORD = 16'hFFFF;

    typedef struct packed {
        logic rx_overflow;
        logic rx_underflow;
        logic tx_overflow;
        logic tx_underrun;
    } sticky_flags_t;

    function automatic logic [31:0] pack_status(input logic [5:0] rx_count,
                                                input logic [5:0] tx_count,
                                                input sticky_flags_t flags);
        logic [31:0] word;
        word = '0;
        word[STATUS_RX_COUNT_LSB +: 6] = rx_count;
        word[STATUS_TX_COUNT_LSB +: 6] = tx_count;
        word[STATUS_RX_OVERFLOW]       = flags.rx_overflow;
        word[STATUS_RX_UNDERFLOW]      = flags.rx_underflow;
        word[STATUS_TX_OVERFLOW]       = flags.tx_overflow;
        word[STATUS_TX_UNDERRUN]       = flags.tx_underrun;
        return word;
    endfunction

    function automatic logic [31:0] pack_ctrl(input logic irq_en);
        logic [31:0] word;
        word = '0;
        word[CTRL_IRQ_EN] = irq_en;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo16.sv
// 16-bit synchronous FIFO with flush; a pop and a push in the same cycle
// both take effect, so a full FIFO accepts a word while it is being drained.
module sync_fifo16 #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [15:0]              push_data,
    output logic [15:0]              head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign head_data = mem[rd_ptr];

    // Popping an empty FIFO does nothing; the freed slot of a real pop lets a full FIFO take a push.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dropped = push && !flush && !do_push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_frame_fifo.sv
// CPU-visible RX/TX frame buffering between an SPI slave and a simple
// memory bus, with sticky error flags and a threshold interrupt.
module spi_frame_fifo
    import spi_frame_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic        tx_load,
    output logic [15:0] tx_data,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_t    state;
    bus_state_t    state_next;
    reg_sel_t      reg_sel;
    logic          access;
    logic          rd_access;
    logic          wr_access;
    logic          data_read;
    logic          data_write;
    logic          ctrl_write;
    logic          thresh_write;
    logic          flush_rx;
    logic          flush_tx;
    logic          clear_flags;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic [5:0]    rx_count6;
    logic [5:0]    tx_count6;
    logic [15:0]   rx_head;
    logic [15:0]   tx_head;
    logic          rx_full;
    logic          rx_empty;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_dropped;
    logic          tx_dropped;
    logic          tx_pop_ok;
    sticky_flags_t flags;
    logic          irq_en;
    logic [5:0]    thresh;
    logic [31:0]   read_mux;
    logic          unused_bits;

    // Every side effect is keyed off the single IDLE->ACK edge of an access.
    assign access     = (state == BUS_IDLE) && sel_in;
    assign rd_access  = access && read_in;
    assign wr_access  = access && !read_in;
    assign reg_sel    = reg_sel_t'(address_in[3:2]);

    assign data_read    = rd_access && (reg_sel == REG_DATA);
    assign data_write   = wr_access && (reg_sel == REG_DATA) && (write_mask_in[1:0] == 2'b11);
    assign ctrl_write   = wr_access && (reg_sel == REG_CTRL) && write_mask_in[0];
    assign thresh_write = wr_access && (reg_sel == REG_THRESH) && write_mask_in[0];
    assign flush_rx     = ctrl_write && write_value_in[CTRL_FLUSH_RX];
    assign flush_tx     = ctrl_write && write_value_in[CTRL_FLUSH_TX];
    assign clear_flags  = ctrl_write && write_value_in[CTRL_CLEAR_FLAGS];

    assign rx_count6 = 6'(rx_count);
    assign tx_count6 = 6'(tx_count);
    assign tx_pop_ok = tx_load && !tx_empty && !flush_tx;
    assign ready_out = (state == BUS_ACK);

    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:2],
                           write_value_in[31:16], rx_full, tx_full};

    sync_fifo16 #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_valid),
        .pop       (data_read),
        .flush     (flush_rx),
        .push_data (rx_data),
        .head_data (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty),
        .dropped   (rx_dropped)
    );

    sync_fifo16 #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_write),
        .pop       (tx_load),
        .flush     (flush_tx),
        .push_data (write_value_in[15:0]),
        .head_data (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty),
        .dropped   (tx_dropped)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUS_IDLE: if (sel_in) state_next = BUS_ACK;
            BUS_ACK:  state_next = BUS_WAIT;
            BUS_WAIT: if (!sel_in) state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        read_mux = '0;
        if (rd_access) begin
            case (reg_sel)
                REG_DATA:   read_mux = rx_empty ? 32'd0 : {15'b0, 1'b1, rx_head};
                REG_STATUS: read_mux = pack_status(rx_count6, tx_count6, flags);
                REG_CTRL:   read_mux = pack_ctrl(irq_en);
                REG_THRESH: read_mux = {26'b0, thresh};
                default:    read_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_value_out <= '0;
        end else begin
            read_value_out <= access ? read_mux : 32'd0;
        end
    end

    // A clear and a fresh error event in the same cycle leave the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            flags.rx_overflow  <= (flags.rx_overflow && !clear_flags) || rx_dropped;
            flags.rx_underflow <= (flags.rx_underflow && !clear_flags) || (data_read && rx_empty);
            flags.tx_overflow  <= (flags.tx_overflow && !clear_flags) || tx_dropped;
            flags.tx_underrun  <= (flags.tx_underrun && !clear_flags) || (tx_load && !tx_pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            thresh <= 6'd1;
        end else begin
            if (ctrl_write) begin
                irq_en <= write_value_in[CTRL_IRQ_EN];
            end
            if (thresh_write) begin
                thresh <= write_value_in[5:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data <= TX_IDLE_WORD;
            irq     <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_data <= tx_pop_ok ? tx_head : TX_IDLE_WORD;
            end
            irq <= irq_en && (rx_count6 >= thresh) && (thresh != 6'd0);
        end
    end

endmodule
